rr_sel_2_1: RTL and testbench
=============================

# rr_sel_2_1

Two-channel round-robin selector stage that sits directly upstream of the 2-1 selector datapath. It arbitrates between request channels A and B, drives the select line (SEL = 0 for A, SEL = 1 for B), and registers the chosen word into a single-entry output slot with a valid/ready handshake. Grants are held for bursts of up to BURST beats, and ties are broken fairly.

## Interface
- W, default 8: data width of DA, DB, OUT.
- BURST, default 4: maximum beats per grant while the other channel waits; legal range ≥1.
- CLK  in  1  rising-edge clock, single clock domain.
- RST  in  1  synchronous, active-high reset.
- REQ_A  in  1  channel A has a word on DA.
- DA  in  W  channel A data.
- ACK_A  out  1  DA consumed this cycle (combinational).
- REQ_B  in  1  channel B has a word on DB.
- DB  in  W  channel B data.
- ACK_B  out  1  DB consumed this cycle (combinational).
- SEL  out  1  current grant: 0 = A (or idle), 1 = B.
- OUT  out  W  registered selected word.
- OUT_VLD  out  1  OUT holds a valid word.
- OUT_RDY  in  1  downstream accepts OUT this cycle.

## Operation
- FSM states: IDLE, GNT_A, GNT_B. Registers: state, LAST (last granted channel), beat counter CNT, OUT, OUT_VLD.
- SEL = 1 iff state = GNT_B.
- Slot free: FREE = !OUT_VLD | OUT_RDY.
- ACK_X = (state = GNT_X) & REQ_X & FREE. ACK is never asserted in IDLE.
- IDLE transitions:
  - Only REQ_A set → GNT_A.
  - Only REQ_B set → GNT_B.
  - Both set → grant the channel that is not LAST.
  - Neither set → stay in IDLE.
  - Every grant entry sets LAST to that channel and sets CNT to 0.
- GNT_X transitions (Y is the other channel), evaluated each cycle in this priority:
  1. !REQ_X → GNT_Y if REQ_Y, else IDLE. CNT ← 0; LAST ← Y on a switch.
  2. ACK_X & CNT = BURST-1 & REQ_Y → GNT_Y. CNT ← 0, LAST ← Y.
  3. ACK_X & CNT = BURST-1 & !REQ_Y → stay in GNT_X. CNT ← 0.
  4. ACK_X → CNT ← CNT+1.
  5. Otherwise hold.
- Output slot:
  - On ACK_X: OUT ← DX, OUT_VLD ← 1.
  - Else if OUT_RDY: OUT_VLD ← 0.
  - OUT is not modified unless a word is loaded.
- CNT width is max(1, clog2(BURST)). With BURST = 1, grants alternate every beat whenever both channels request.
- A word must not be lost or duplicated under any combination of REQ_A, REQ_B and OUT_RDY.

## Timing
- Reset values: state = IDLE, LAST = B (so A wins the first tie), CNT = 0, OUT = 0, OUT_VLD = 0, SEL = 0, ACK_A = ACK_B = 0.
- Latency from IDLE: REQ asserted at cycle 0 → grant at cycle 1 (ACK at cycle 1 if FREE) → OUT_VLD at cycle 2.
- Throughput: one beat per cycle during a grant while OUT_RDY = 1.
- Switch cost: a direct GNT_A↔GNT_B switch has no idle cycle. The new channel may be ACKed on the first cycle of its grant.
- Backpressure: OUT_VLD = 1 with OUT_RDY = 0 forces ACK = 0, and OUT and OUT_VLD hold. The grant holds while REQ_X stays high.
- Simultaneous load and drain (OUT_VLD & OUT_RDY & ACK): the new word replaces the old one and OUT_VLD stays 1.
- Requesters must keep REQ and data stable until ACK. A REQ drop before ACK takes effect under rule 1, with no ACK.
- RST mid-burst, on the clock edge where it is sampled:
  - all state returns to reset values;
  - OUT_VLD clears, so a pending word is discarded;
  - ACK is 0 in that cycle.

## Structure
- Shared package sel_pkg holds:
  - the state encoding IDLE = 2'b00, GNT_A = 2'b01, GNT_B = 2'b10;
  - channel identifiers CH_A = 1'b0, CH_B = 1'b1, reused by the 2-1 selector as SEL values.
- One natural sub-module, out_slot: W-wide single-entry register with load, OUT_RDY drain, OUT and OUT_VLD.
- Arbiter FSM, CNT, LAST and ACK logic live in rr_sel_2_1.

## Test plan
- Single channel: REQ_A = 1, DA = 8'h11, OUT_RDY = 1 → SEL = 0; ACK_A at cycle 1; OUT = 8'h11 with OUT_VLD = 1 at cycle 2.
- Tie after reset: REQ_A = REQ_B = 1 held, BURST = 4, DA/DB count up, OUT_RDY = 1 → A, A, A, A, then B, B, B, B. SEL toggles on the cycle after the 4th ACK, with no bubble on OUT_VLD.
- Backpressure: OUT_RDY = 0 for 5 cycles with REQ_B held and OUT = 8'h22 pending → ACK_B = 0 and OUT stable at 8'h22. OUT_RDY = 1 → OUT_RDY and ACK_B are asserted together and the next DB loads.
- Early release: REQ_A drops after 2 beats, REQ_B = 1 → direct switch to GNT_B, LAST = B, CNT = 0; the next tie grants A.
- BURST = 1, both requesting → grants alternate A, B, A, B on consecutive beats.
- RST pulse mid-burst with OUT_VLD = 1 → next cycle state = IDLE, OUT_VLD = 0, OUT = 0, SEL = 0, and A wins the next tie.

Source files
------------

// File: rtl/sel_pkg.sv
// Shared encodings for the 2-1 round-robin selector stage:
// FSM state codes and channel IDs (reused as SEL values).
package sel_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_A = 2'b01;
  localparam logic [1:0] GNT_B = 2'b10;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/rr_sel_2_1_out_slot.sv
// Single-entry output register for the selector stage:
// loads on accept, drains when downstream takes it.
module out_slot #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  input  logic         rdy_i,
  output logic [W-1:0] q_o,
  output logic         vld_o
);

  logic [W-1:0] q_q;
  logic         vld_q;

  // A load wins over a drain so a simultaneous
  // load+drain keeps the slot full with the new word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else if (load_i) begin
      q_q   <= d_i;
      vld_q <= 1'b1;
    end else if (rdy_i) begin
      vld_q <= 1'b0;
    end
  end

  assign q_o   = q_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/rr_sel_2_1.sv
// Two-channel round-robin selector with burst-limited
// grants feeding a registered single-entry output slot.
module rr_sel_2_1
  import sel_pkg::*;
#(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ_A,
  input  logic [W-1:0] DA,
  output logic         ACK_A,
  input  logic         REQ_B,
  input  logic [W-1:0] DB,
  output logic         ACK_B,
  output logic         SEL,
  output logic [W-1:0] OUT,
  output logic         OUT_VLD,
  input  logic         OUT_RDY
);

  localparam int CW = (BURST <= 2) ? 1 : $clog2(BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          free;
  logic          cur_b;
  logic          req_x, req_y, ack_x;
  logic [1:0]    y_st;
  logic          y_ch;
  logic          pick_a;
  logic [W-1:0]  load_d;

  assign free  = !OUT_VLD || OUT_RDY;
  assign ACK_A = !RST && (state_q == GNT_A)
                 && REQ_A && free;
  assign ACK_B = !RST && (state_q == GNT_B)
                 && REQ_B && free;
  assign SEL   = (state_q == GNT_B);

  // View of the granted channel (X) and the other (Y).
  assign cur_b  = (state_q == GNT_B);
  assign req_x  = cur_b ? REQ_B : REQ_A;
  assign req_y  = cur_b ? REQ_A : REQ_B;
  assign ack_x  = ACK_A || ACK_B;
  assign y_st   = cur_b ? GNT_A : GNT_B;
  assign y_ch   = cur_b ? CH_A : CH_B;
  assign pick_a = REQ_A && (!REQ_B || last_q == CH_B);
  assign load_d = ACK_B ? DB : DA;

  // Arbiter next-state: tie-break on LAST, burst limit on CNT.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_a) begin
          state_d = GNT_A;
          last_d  = CH_A;
          cnt_d   = '0;
        end else if (REQ_B) begin
          state_d = GNT_B;
          last_d  = CH_B;
          cnt_d   = '0;
        end
      end
      GNT_A, GNT_B: begin
        if (!req_x) begin
          cnt_d = '0;
          if (req_y) begin
            state_d = y_st;
            last_d  = y_ch;
          end else begin
            state_d = IDLE;
          end
        end else if (ack_x) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (req_y) begin
              state_d = y_st;
              last_d  = y_ch;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter registers; LAST resets to B so A wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= CH_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  out_slot #(
    .W (W)
  ) u_slot (
    .CLK    (CLK),
    .RST    (RST),
    .load_i (ack_x),
    .d_i    (load_d),
    .rdy_i  (OUT_RDY),
    .q_o    (OUT),
    .vld_o  (OUT_VLD)
  );

endmodule

// File: tb/tb_rr_sel_2_1.sv
// Directed bench for rr_sel_2_1: BURST=4 main instance
// plus a BURST=1 instance for per-beat alternation.
module tb_rr_sel_2_1;

  logic       CLK;
  logic       RST;
  logic       REQ_A, REQ_B, OUT_RDY;
  logic [7:0] DA, DB;
  logic       ACK_A, ACK_B, SEL, OUT_VLD;
  logic [7:0] OUT;

  logic       r1a, r1b, rdy1;
  logic [7:0] d1a, d1b;
  logic       ack1a, ack1b, sel1, vld1;
  logic [7:0] out1;

  int passed = 0;
  int total  = 0;

  rr_sel_2_1 #(.W(8), .BURST(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .DA(DA), .ACK_A(ACK_A),
    .REQ_B(REQ_B), .DB(DB), .ACK_B(ACK_B),
    .SEL(SEL), .OUT(OUT), .OUT_VLD(OUT_VLD),
    .OUT_RDY(OUT_RDY)
  );

  rr_sel_2_1 #(.W(8), .BURST(1)) dut1 (
    .CLK(CLK), .RST(RST),
    .REQ_A(r1a), .DA(d1a), .ACK_A(ack1a),
    .REQ_B(r1b), .DB(d1b), .ACK_B(ack1b),
    .SEL(sel1), .OUT(out1), .OUT_VLD(vld1),
    .OUT_RDY(rdy1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    logic       es;
    logic [7:0] eo;
    RST = 1'b1;
    REQ_A = 0; REQ_B = 0; OUT_RDY = 1;
    DA = 0; DB = 0;
    r1a = 0; r1b = 0; rdy1 = 1;
    d1a = 8'hAA; d1b = 8'hBB;
    step();
    step();
    RST = 1'b0;

    // reset state
    mid();
    chk("rst_sel", SEL, 0);
    chk("rst_acka", ACK_A, 0);
    chk("rst_ackb", ACK_B, 0);
    chk("rst_vld", OUT_VLD, 0);
    chk("rst_out", OUT, 0);
    step();

    // single channel A
    REQ_A = 1; DA = 8'h11;
    mid();
    chk("s_c0_acka", ACK_A, 0);
    step();
    mid();
    chk("s_c1_acka", ACK_A, 1);
    chk("s_c1_sel", SEL, 0);
    chk("s_c1_vld", OUT_VLD, 0);
    step();
    REQ_A = 0;
    mid();
    chk("s_c2_vld", OUT_VLD, 1);
    chk("s_c2_out", OUT, 8'h11);
    chk("s_c2_acka", ACK_A, 0);
    step();
    mid();
    chk("s_c3_vld", OUT_VLD, 0);
    chk("s_c3_out", OUT, 8'h11);
    step();

    // reset pulse clears OUT and restores LAST = B
    RST = 1;
    step();
    RST = 0;
    mid();
    chk("rst2_out", OUT, 0);
    step();

    // tie after reset: A x4 then B x4 then A
    REQ_A = 1; REQ_B = 1; DA = 8'hA0; DB = 8'hB0;
    mid();
    chk("t_c0_acka", ACK_A, 0);
    step();
    eo = 8'h00;
    for (int c = 1; c <= 9; c++) begin
      es = (c >= 5 && c <= 8);
      mid();
      chk($sformatf("t_c%0d_sel", c), SEL, es);
      chk($sformatf("t_c%0d_acka", c), ACK_A, !es);
      chk($sformatf("t_c%0d_ackb", c), ACK_B, es);
      if (c >= 2) begin
        chk($sformatf("t_c%0d_vld", c), OUT_VLD, 1);
        chk($sformatf("t_c%0d_out", c), OUT, eo);
      end
      eo = es ? DB : DA;
      step();
      if (es) DB = DB + 1;
      else    DA = DA + 1;
    end

    // backpressure on B with 8'h22 pending
    REQ_A = 0; REQ_B = 1; DB = 8'h22;
    mid();
    chk("bp_sw_acka", ACK_A, 0);
    step();
    mid();
    chk("bp_ackb", ACK_B, 1);
    chk("bp_sel", SEL, 1);
    step();
    DB = 8'h33; OUT_RDY = 0;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk($sformatf("bp%0d_ackb", c), ACK_B, 0);
      chk($sformatf("bp%0d_out", c), OUT, 8'h22);
      chk($sformatf("bp%0d_vld", c), OUT_VLD, 1);
      step();
    end
    OUT_RDY = 1;
    mid();
    chk("bp_rel_ackb", ACK_B, 1);
    chk("bp_rel_out", OUT, 8'h22);
    step();
    REQ_B = 0;
    mid();
    chk("bp_new_out", OUT, 8'h33);
    step();

    // early release: A for 2 beats, then direct switch
    REQ_A = 1; REQ_B = 1; DA = 8'h40; DB = 8'h50;
    mid();
    chk("er_idle_acka", ACK_A, 0);
    step();
    for (int c = 0; c < 2; c++) begin
      mid();
      chk($sformatf("er_a%0d_acka", c), ACK_A, 1);
      step();
      DA = DA + 1;
    end
    REQ_A = 0;
    mid();
    chk("er_drop_acka", ACK_A, 0);
    chk("er_drop_sel", SEL, 0);
    step();
    REQ_A = 1;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("er_b%0d_sel", c), SEL, 1);
      chk($sformatf("er_b%0d_ackb", c), ACK_B, 1);
      step();
      DB = DB + 1;
    end
    mid();
    chk("er_back_sel", SEL, 0);
    chk("er_back_acka", ACK_A, 1);
    chk("er_back_out", OUT, 8'h53);
    step();
    REQ_A = 0; REQ_B = 0;
    mid();
    step();

    // reset mid-burst with a word pending (LAST=A so B wins)
    REQ_A = 1; REQ_B = 1;
    mid();
    step();
    mid();
    chk("mr_ackb", ACK_B, 1);
    step();
    RST = 1;
    mid();
    chk("mr_rst_ackb", ACK_B, 0);
    chk("mr_rst_vld", OUT_VLD, 1);
    step();
    RST = 0;
    mid();
    chk("mr_sel", SEL, 0);
    chk("mr_vld", OUT_VLD, 0);
    chk("mr_out", OUT, 0);
    chk("mr_acka", ACK_A, 0);
    step();
    mid();
    chk("mr_tie_acka", ACK_A, 1);
    chk("mr_tie_sel", SEL, 0);
    step();
    REQ_A = 0; REQ_B = 0;

    // BURST = 1: alternate every beat
    r1a = 1; r1b = 1;
    mid();
    chk("b1_c0_acka", ack1a, 0);
    step();
    for (int c = 1; c <= 5; c++) begin
      es = (c % 2 == 0);
      mid();
      chk($sformatf("b1_c%0d_sel", c), sel1, es);
      chk($sformatf("b1_c%0d_acka", c), ack1a, !es);
      chk($sformatf("b1_c%0d_ackb", c), ack1b, es);
      if (c >= 2)
        chk($sformatf("b1_c%0d_out", c), out1,
            es ? 8'hAA : 8'hBB);
      step();
    end
    r1a = 0; r1b = 0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
